// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter.
// MORSE_DIGITS_EN adds 5-element codes for the digits '0'-'9'.
package morse_pkg;

`ifdef MORSE_DIGITS_EN
  localparam int unsigned MAX_LEN = 5;
`else
  localparam int unsigned MAX_LEN = 4;
`endif
  localparam int unsigned LEN_W          = $clog2(MAX_LEN + 1);
  localparam int unsigned PAT_W          = MAX_LEN;
  localparam int unsigned ELEM_W         = 3;
  localparam int unsigned UNITS_W        = 3;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned CHAR_GAP_UNITS = 3;

  localparam logic [1:0] SYM_END  = 2'd0;
  localparam logic [1:0] SYM_DOT  = 2'd1;
  localparam logic [1:0] SYM_DASH = 2'd2;

  typedef enum logic [1:0] {IDLE, MARK, GAP, CHAR_GAP} state_t;

  // Pattern is MSB-first within the low len bits; bit value 1 = dash.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } morse_code_t;

  function automatic morse_code_t mc(input int unsigned len, input int unsigned pat);
    morse_code_t c;
    c.len     = LEN_W'(len);
    c.pattern = PAT_W'(pat);
    return c;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII -> Morse code lookup; lowercase letters fold to uppercase.
// Digits are encoded only when MORSE_DIGITS_EN is defined.
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0]  char_in,
  output logic        ok_c,
  output morse_code_t code_c
);

  logic [7:0] ch;

  always_comb begin
    ch     = char_in;
    ok_c   = 1'b1;
    code_c = '0;
    if (char_in >= 8'h61 && char_in <= 8'h7a) ch = char_in - 8'h20;
    case (ch)
      8'h41: code_c = mc(2, 'b01);
      8'h42: code_c = mc(4, 'b1000);
      8'h43: code_c = mc(4, 'b1010);
      8'h44: code_c = mc(3, 'b100);
      8'h45: code_c = mc(1, 'b0);
      8'h46: code_c = mc(4, 'b0010);
      8'h47: code_c = mc(3, 'b110);
      8'h48: code_c = mc(4, 'b0000);
      8'h49: code_c = mc(2, 'b00);
      8'h4a: code_c = mc(4, 'b0111);
      8'h4b: code_c = mc(3, 'b101);
      8'h4c: code_c = mc(4, 'b0100);
      8'h4d: code_c = mc(2, 'b11);
      8'h4e: code_c = mc(2, 'b10);
      8'h4f: code_c = mc(3, 'b111);
      8'h50: code_c = mc(4, 'b0110);
      8'h51: code_c = mc(4, 'b1101);
      8'h52: code_c = mc(3, 'b010);
      8'h53: code_c = mc(3, 'b000);
      8'h54: code_c = mc(1, 'b1);
      8'h55: code_c = mc(3, 'b001);
      8'h56: code_c = mc(4, 'b0001);
      8'h57: code_c = mc(3, 'b011);
      8'h58: code_c = mc(4, 'b1001);
      8'h59: code_c = mc(4, 'b1011);
      8'h5a: code_c = mc(4, 'b1100);
`ifdef MORSE_DIGITS_EN
      8'h30: code_c = mc(5, 'b11111);
      8'h31: code_c = mc(5, 'b01111);
      8'h32: code_c = mc(5, 'b00111);
      8'h33: code_c = mc(5, 'b00011);
      8'h34: code_c = mc(5, 'b00001);
      8'h35: code_c = mc(5, 'b00000);
      8'h36: code_c = mc(5, 'b10000);
      8'h37: code_c = mc(5, 'b11000);
      8'h38: code_c = mc(5, 'b11100);
      8'h39: code_c = mc(5, 'b11110);
`endif
      default: ok_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/char_to_morse.sv
// Morse transmitter: takes one ASCII char per handshake and keys its pattern with unit timing.
// MORSE_DIGITS_EN (see morse_pkg / morse_lut) enables digit codes.
module char_to_morse
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  output logic       key_out,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic       err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(UNIT_CYCLES);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     unit_cnt, unit_cnt_nxt;
  logic [UNITS_W-1:0]   units_left, units_left_nxt;
  logic [ELEM_W-1:0]    elem_idx, elem_idx_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  logic [PAT_W-1:0]     pat_q, pat_nxt;
  logic                 key_nxt, sym_valid_nxt, err_nxt;
  logic [1:0]           sym_code_nxt;

  logic                 lut_ok_c;
  morse_code_t          lut_code_c;
  logic [PAT_W-1:0]     pat_aligned_c;
  logic                 transfer_c, unit_done_c, seg_end_c, more_c;

  morse_lut u_lut (
    .char_in (char_in),
    .ok_c    (lut_ok_c),
    .code_c  (lut_code_c)
  );

  // Left-align the pattern so the current element is always the top bit.
  assign pat_aligned_c = lut_code_c.pattern << (LEN_W'(MAX_LEN) - lut_code_c.len);
  assign transfer_c    = char_valid & char_ready;
  assign unit_done_c   = (unit_cnt == CNT_W'(UNIT_CYCLES - 1));
  assign seg_end_c     = unit_done_c && (units_left == '0);
  assign more_c        = (elem_idx + ELEM_W'(1)) < ELEM_W'(len_q);

  always_comb begin
    state_nxt      = state;
    unit_cnt_nxt   = unit_done_c ? '0 : unit_cnt + CNT_W'(1);
    units_left_nxt = unit_done_c ? units_left - UNITS_W'(1) : units_left;
    elem_idx_nxt   = elem_idx;
    len_nxt        = len_q;
    pat_nxt        = pat_q;
    key_nxt        = 1'b0;
    sym_valid_nxt  = 1'b0;
    sym_code_nxt   = SYM_END;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        unit_cnt_nxt   = '0;
        units_left_nxt = '0;
        if (transfer_c) begin
          if (lut_ok_c) begin
            state_nxt      = MARK;
            len_nxt        = lut_code_c.len;
            pat_nxt        = pat_aligned_c;
            elem_idx_nxt   = '0;
            units_left_nxt = pat_aligned_c[PAT_W-1] ? UNITS_W'(DASH_UNITS - 1) : '0;
            key_nxt        = 1'b1;
            sym_valid_nxt  = 1'b1;
            sym_code_nxt   = pat_aligned_c[PAT_W-1] ? SYM_DASH : SYM_DOT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      MARK: begin
        key_nxt = 1'b1;
        if (seg_end_c) begin
          key_nxt = 1'b0;
          if (more_c) begin
            state_nxt      = GAP;
            units_left_nxt = '0;
          end else begin
            state_nxt      = CHAR_GAP;
            units_left_nxt = UNITS_W'(CHAR_GAP_UNITS - 1);
            sym_valid_nxt  = 1'b1;
            sym_code_nxt   = SYM_END;
          end
        end
      end
      GAP: begin
        if (seg_end_c) begin
          state_nxt      = MARK;
          pat_nxt        = pat_q << 1;
          elem_idx_nxt   = elem_idx + ELEM_W'(1);
          units_left_nxt = pat_q[PAT_W-2] ? UNITS_W'(DASH_UNITS - 1) : '0;
          key_nxt        = 1'b1;
          sym_valid_nxt  = 1'b1;
          sym_code_nxt   = pat_q[PAT_W-2] ? SYM_DASH : SYM_DOT;
        end
      end
      CHAR_GAP: begin
        if (seg_end_c) begin
          state_nxt      = IDLE;
          units_left_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      unit_cnt   <= '0;
      units_left <= '0;
      elem_idx   <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      char_ready <= 1'b1;
      key_out    <= 1'b0;
      sym_valid  <= 1'b0;
      sym_code   <= SYM_END;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      unit_cnt   <= unit_cnt_nxt;
      units_left <= units_left_nxt;
      elem_idx   <= elem_idx_nxt;
      len_q      <= len_nxt;
      pat_q      <= pat_nxt;
      char_ready <= (state_nxt == IDLE);
      key_out    <= key_nxt;
      sym_valid  <= sym_valid_nxt;
      sym_code   <= sym_code_nxt;
      err        <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_char_to_morse.sv
// Directed bench for char_to_morse with UNIT_CYCLES=4 (one unit = 4 clocks).
module tb_char_to_morse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_ready, key_out, sym_valid, err, busy;
  logic [1:0] sym_code;

  int         tests = 0;
  int         fails = 0;
  logic [15:0] syms;
  int          nsym;

  always #5 clk = ~clk;

  char_to_morse #(.UNIT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .key_out    (key_out),
    .sym_valid  (sym_valid),
    .sym_code   (sym_code),
    .err        (err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_syms();
    syms = '0;
    nsym = 0;
  endtask

  // Expect key_out == v for n cycles, logging any symbol strobes seen.
  task automatic run(input logic v, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (key_out !== v) bad++;
      if (sym_valid === 1'b1) begin
        syms = {syms[13:0], sym_code};
        nsym++;
      end
      cyc();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Present c for one transfer; returns one cycle after the transfer edge.
  task automatic send(input logic [7:0] c, input string tag);
    char_valid = 1'b1;
    char_in    = c;
    check({tag, "_ready_pre"}, 32'(char_ready), 32'd1);
    cyc();
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic play_e(input string tag);
    clear_syms();
    send(8'h45, tag);
    check({tag, "_ready_drop"}, 32'(char_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    run(1'b1, 4, {tag, "_mark"});
    run(1'b0, 12, {tag, "_chargap"});
    check({tag, "_ready_back"}, 32'(char_ready), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_syms"}, 32'(syms), 32'h4);
    check({tag, "_nsym"}, 32'(nsym), 32'd2);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    check("rst_ready", 32'(char_ready), 32'd1);
    check("rst_key", 32'(key_out), 32'd0);
    check("rst_symv", 32'(sym_valid), 32'd0);
    check("rst_symc", 32'(sym_code), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc();

    play_e("e");

    // Lowercase k: dash dot dash
    clear_syms();
    send(8'h6b, "k");
    run(1'b1, 12, "k_dash1");
    run(1'b0, 4, "k_gap1");
    run(1'b1, 4, "k_dot");
    run(1'b0, 4, "k_gap2");
    run(1'b1, 12, "k_dash2");
    run(1'b0, 12, "k_chargap");
    check("k_syms", 32'(syms), 32'h98);
    check("k_nsym", 32'(nsym), 32'd4);
    check("k_ready", 32'(char_ready), 32'd1);

    // Invalid char
    send(8'h23, "hash");
    check("hash_err", 32'(err), 32'd1);
    check("hash_key", 32'(key_out), 32'd0);
    check("hash_symv", 32'(sym_valid), 32'd0);
    check("hash_ready", 32'(char_ready), 32'd1);
    cyc();
    check("hash_err_clr", 32'(err), 32'd0);
    check("hash_busy", 32'(busy), 32'd0);

    // T then A held back-to-back; char_in changes while busy are ignored
    clear_syms();
    send(8'h54, "t");
    char_valid = 1'b1;
    char_in    = 8'h41;
    check("t_ready_drop", 32'(char_ready), 32'd0);
    run(1'b1, 12, "t_dash");
    run(1'b0, 12, "ta_chargap");
    check("ta_idle_key", 32'(key_out), 32'd0);
    check("ta_ready", 32'(char_ready), 32'd1);
    cyc();
    char_valid = 1'b0;
    check("a_ready_drop", 32'(char_ready), 32'd0);
    run(1'b1, 4, "a_dot");
    run(1'b0, 4, "a_gap");
    run(1'b1, 12, "a_dash");
    run(1'b0, 12, "a_chargap");
    check("ta_syms", 32'(syms), 32'h218);
    check("ta_nsym", 32'(nsym), 32'd5);
    check("ta_ready_end", 32'(char_ready), 32'd1);

    // Async reset in the middle of M's first dash
    send(8'h4d, "m");
    run(1'b1, 6, "m_dash_part");
    #2 rst_n = 1'b0;
    #1;
    check("m_rst_key", 32'(key_out), 32'd0);
    check("m_rst_busy", 32'(busy), 32'd0);
    check("m_rst_ready", 32'(char_ready), 32'd1);
    #1 rst_n = 1'b1;
    cyc();
    check("m_post_key", 32'(key_out), 32'd0);
    check("m_post_ready", 32'(char_ready), 32'd1);
    check("m_post_symv", 32'(sym_valid), 32'd0);
    play_e("e2");

    // Digit '5'
    clear_syms();
    send(8'h35, "five");
`ifdef MORSE_DIGITS_EN
    check("five_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run(1'b1, 4, "five_dot");
      run(1'b0, 4, "five_gap");
    end
    run(1'b1, 4, "five_dot5");
    run(1'b0, 12, "five_chargap");
    check("five_syms", 32'(syms), 32'h554);
    check("five_nsym", 32'(nsym), 32'd6);
    check("five_ready", 32'(char_ready), 32'd1);
`else
    check("five_err", 32'(err), 32'd1);
    check("five_key", 32'(key_out), 32'd0);
    check("five_symv", 32'(sym_valid), 32'd0);
    check("five_ready", 32'(char_ready), 32'd1);
    run(1'b0, 4, "five_silent");
    check("five_nsym", 32'(nsym), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
